// File: rtl/pl_controller_pkg.sv
// Shared definitions for the pipeline-stage sequencer: beat state encoding and
// the default pipeline depth / per-beat watchdog limit.
package pl_controller_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_HALT  = 2'd3
   } pl_state_t;

   localparam int NUM_STAGES_DEF = 7;
   localparam int TIMEOUT_DEF    = 65535;
   localparam int CNT_W          = 16;

endpackage

// File: rtl/pl_controller_if.sv
// Job/stage handshake bundle between the beat sequencer (master) and the
// pipeline datapath plus job source (slave).
interface pl_controller_if
   import pl_controller_pkg::*;
#(
   parameter int NUM_STAGES = NUM_STAGES_DEF
) ();

   logic                  en;
   logic                  job_req;
   logic                  job_ack;
   logic [NUM_STAGES-1:0] stage_done;
   logic [NUM_STAGES-1:0] stage_start;
   logic [NUM_STAGES-1:0] occupancy;
   logic                  job_done;
   logic                  busy;
   logic                  err;

   modport master (
      input  en, job_req, stage_done,
      output job_ack, stage_start, occupancy, job_done, busy, err
   );

   modport slave (
      output en, job_req, stage_done,
      input  job_ack, stage_start, occupancy, job_done, busy, err
   );

endinterface

// File: rtl/pl_controller_done_collector.sv
// Per-stage sticky done register: accumulates masked done bits across a beat
// and reports when every occupied stage has finished (including this cycle).
module pl_controller_done_collector
   import pl_controller_pkg::*;
#(
   parameter int NUM_STAGES = NUM_STAGES_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  capture,
   input  logic [NUM_STAGES-1:0] done_in,
   input  logic [NUM_STAGES-1:0] mask,
   output logic                  all_done
);

   logic [NUM_STAGES-1:0] done_seen;
   logic [NUM_STAGES-1:0] merged;

   // Merging the live inputs lets the beat end on the edge after the last done.
   assign merged   = done_seen | (done_in & mask);
   assign all_done = (merged == mask);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done_seen <= '0;
      end else if (clr) begin
         done_seen <= '0;
      end else if (capture) begin
         done_seen <= merged;
      end
   end

endmodule

// File: rtl/pl_controller.sv
// Beat sequencer for a NUM_STAGES-deep ping-pong pipeline: shifts jobs one
// stage per beat, pulses stage starts and waits for every occupied stage.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | between beats; a beat begins when en and (job_req or occupied)
//  ST_START | one cycle, stage_start pulses, done register and counter clear
//  ST_WAIT  | collect stage done bits; leave when all occupied stages done
//  ST_HALT  | watchdog expired; frozen until reset
module pl_controller
   import pl_controller_pkg::*;
#(
   parameter int NUM_STAGES = NUM_STAGES_DEF,
   parameter int TIMEOUT    = TIMEOUT_DEF
) (
   input  logic            clk,
   input  logic            rst,
   pl_controller_if.master bus
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   pl_state_t             state, state_nx;
   logic [NUM_STAGES-1:0] occ, occ_nx;
   logic [NUM_STAGES-1:0] start_q, start_nx;
   logic [CNT_W-1:0]      cnt, cnt_nx;
   logic                  ack_q, ack_nx;
   logic                  jdone_q, jdone_nx;
   logic                  err_q, err_nx;
   logic                  all_done;
   logic                  beat_go;
   logic [NUM_STAGES-1:0] occ_shift;

   assign occ_shift = {occ[NUM_STAGES-2:0], bus.job_req};
   assign beat_go   = bus.en & (bus.job_req | (|occ));

   pl_controller_done_collector #(.NUM_STAGES(NUM_STAGES)) u_done (
      .clk      (clk),
      .rst      (rst),
      .clr      (state == ST_START),
      .capture  (state == ST_WAIT),
      .done_in  (bus.stage_done),
      .mask     (occ),
      .all_done (all_done)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_IDLE;
         occ     <= '0;
         start_q <= '0;
         cnt     <= '0;
         ack_q   <= 1'b0;
         jdone_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_nx;
         occ     <= occ_nx;
         start_q <= start_nx;
         cnt     <= cnt_nx;
         ack_q   <= ack_nx;
         jdone_q <= jdone_nx;
         err_q   <= err_nx;
      end
   end

   always_comb begin
      state_nx = state;
      occ_nx   = occ;
      cnt_nx   = cnt;
      start_nx = '0;
      ack_nx   = 1'b0;
      jdone_nx = 1'b0;
      err_nx   = err_q;
      unique case (state)
         ST_IDLE: begin
            if (beat_go) begin
               occ_nx   = occ_shift;
               ack_nx   = bus.job_req;
               start_nx = occ_shift;
               state_nx = ST_START;
            end
         end
         ST_START: begin
            cnt_nx   = '0;
            state_nx = ST_WAIT;
         end
         ST_WAIT: begin
            // A beat that completes on the watchdog's last cycle still counts as done.
            if (all_done) begin
               state_nx = ST_IDLE;
               jdone_nx = occ[NUM_STAGES-1];
            end else if (cnt == CNT_LAST) begin
               err_nx   = 1'b1;
               state_nx = ST_HALT;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

   assign bus.job_ack     = ack_q;
   assign bus.stage_start = start_q;
   assign bus.occupancy   = occ;
   assign bus.job_done    = jdone_q;
   assign bus.err         = err_q;
   assign bus.busy        = (state != ST_IDLE) | (|occ);

endmodule

// File: tb/tb_pl_controller.sv
// Bench for pl_controller: beat-level reference model compared every cycle,
// directed scenarios with hand-computed expectations, then random episodes.
module tb_pl_controller;

   localparam int N  = pl_controller_pkg::NUM_STAGES_DEF;
   localparam int TO = 20;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   pl_controller_if #(.NUM_STAGES(N)) bus ();

   pl_controller #(.NUM_STAGES(N), .TIMEOUT(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Reference model: jobs advance one stage per beat; a beat is one start
   // cycle followed by wait cycles until every occupied stage reported done.
   bit [N-1:0] m_occ, m_seen, m_start;
   bit         m_beat, m_halt, m_err, m_ack, m_jdone;
   int         m_age;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_occ = '0; m_seen = '0; m_start = '0;
         m_beat = 0; m_halt = 0; m_err = 0; m_ack = 0; m_jdone = 0; m_age = 0;
      end else begin
         m_ack = 0; m_start = '0; m_jdone = 0;
         if (m_halt) begin
         end else if (!m_beat) begin
            if (bus.en && (bus.job_req || m_occ != 0)) begin
               m_occ   = (m_occ << 1) | N'(bus.job_req);
               m_ack   = bus.job_req;
               m_start = m_occ;
               m_beat  = 1;
               m_age   = 0;
            end
         end else if (m_age == 0) begin
            m_seen = '0;
            m_age  = 1;
         end else begin
            m_seen = m_seen | (bus.stage_done & m_occ);
            if (m_seen == m_occ) begin
               m_beat  = 0;
               m_jdone = m_occ[N-1];
            end else if (m_age == TO) begin
               m_halt = 1;
               m_err  = 1;
            end else begin
               m_age++;
            end
         end
      end
   end

   int cyc = 0, n_ack = 0, n_jdone = 0, n_beats = 0;
   int ack_cyc = 0, jdone_cyc = 0, start_cyc = 0;
   int done_beats[$];

   always @(negedge clk) begin
      cyc++;
      if (bus.job_ack) begin n_ack++; ack_cyc = cyc; end
      if (bus.stage_start != '0) begin n_beats++; start_cyc = cyc; end
      if (bus.job_done) begin n_jdone++; jdone_cyc = cyc; done_beats.push_back(n_beats); end
      check("job_ack",     32'(bus.job_ack),     32'(m_ack));
      check("stage_start", 32'(bus.stage_start), 32'(m_start));
      check("occupancy",   32'(bus.occupancy),   32'(m_occ));
      check("job_done",    32'(bus.job_done),    32'(m_jdone));
      check("err",         32'(bus.err),         32'(m_err));
      check("busy",        32'(bus.busy),        32'(m_beat || m_halt || m_occ != 0));
   end

   // Stage responder: each started stage reports done a set number of cycles later.
   int         cd [N];
   bit         resp_on = 0, rand_dly = 0, noise_on = 0;
   int         fix_dly = 5, dly_max = 12;
   logic [N-1:0] man_done = '0;

   always @(posedge clk) begin
      logic [N-1:0] rd, nz;
      #2;
      rd = '0;
      for (int i = 0; i < N; i++) begin
         if (bus.stage_start[i]) cd[i] = rand_dly ? int'($urandom_range(1, dly_max)) : fix_dly;
         else if (cd[i] >= 0) cd[i]--;
         rd[i] = (cd[i] == 0);
      end
      nz = noise_on ? (N'($urandom) & N'($urandom) & N'($urandom)) : '0;
      bus.stage_done = (resp_on ? rd : '0) | man_done | nz;
   end

   task automatic drive_edge();
      @(posedge clk); #1;
   endtask

   task automatic step_neg();
      @(negedge clk); #1;
   endtask

   function automatic int cnt_of(input int sel);
      case (sel)
         0:       return n_ack;
         1:       return n_jdone;
         default: return n_beats;
      endcase
   endfunction

   task automatic wait_cnt(input int sel, input int target, input int lim, input string nm);
      int k;
      k = 0;
      while (cnt_of(sel) < target && k < lim) begin step_neg(); k++; end
      checks++;
      if (cnt_of(sel) < target) begin
         errors++;
         $display("FAIL %s wait expired count=%0d required=%0d", nm, cnt_of(sel), target);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog simulation time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int b_ack, b_jd, b_beats, b_q, s, s2, db0, db1;
      for (int i = 0; i < N; i++) cd[i] = -1;
      bus.en = 0; bus.job_req = 0; bus.stage_done = '0;
      rst = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ack",   32'(bus.job_ack),     0);
      check("rst_start", 32'(bus.stage_start), 0);
      check("rst_occ",   32'(bus.occupancy),   0);
      check("rst_jdone", 32'(bus.job_done),    0);
      check("rst_busy",  32'(bus.busy),        0);
      check("rst_err",   32'(bus.err),         0);
      rst = 1;

      // en low holds a pending job off; the beat starts on the edge after en rises
      bus.job_req = 1; resp_on = 1; fix_dly = 5;
      repeat (5) begin
         drive_edge(); step_neg();
         check("gated_ack",   32'(bus.job_ack),     0);
         check("gated_start", 32'(bus.stage_start), 0);
      end
      b_ack = n_ack; b_jd = n_jdone; b_beats = n_beats; b_q = done_beats.size();
      drive_edge(); bus.en = 1;
      step_neg();
      check("en_same_cycle_ack", 32'(bus.job_ack), 0);
      step_neg();
      check("en_next_edge_ack", 32'(bus.job_ack),     1);
      check("first_start",      32'(bus.stage_start), 1);
      drive_edge(); bus.job_req = 0;

      // single job through 7 beats of 7 cycles each
      wait_cnt(1, b_jd + 1, 200, "single_done");
      check("single_latency", 32'(jdone_cyc - ack_cyc), 48);
      db0 = (done_beats.size() > b_q) ? done_beats[b_q] - b_beats : -1;
      check("single_done_beat", 32'(db0), 7);
      repeat (10) step_neg();
      check("single_acks",  32'(n_ack - b_ack), 1);
      check("drained_occ",  32'(bus.occupancy), 0);
      check("drained_busy", 32'(bus.busy),      0);

      // two back-to-back jobs
      b_ack = n_ack; b_jd = n_jdone; b_beats = n_beats; b_q = done_beats.size();
      drive_edge(); bus.job_req = 1;
      wait_cnt(0, b_ack + 1, 20, "two_ack1");
      check("two_occ1", 32'(bus.occupancy), 32'h01);
      wait_cnt(0, b_ack + 2, 40, "two_ack2");
      check("two_occ2", 32'(bus.occupancy), 32'h03);
      drive_edge(); bus.job_req = 0;
      wait_cnt(1, b_jd + 2, 300, "two_done");
      db0 = (done_beats.size() > b_q)     ? done_beats[b_q] - b_beats     : -1;
      db1 = (done_beats.size() > b_q + 1) ? done_beats[b_q + 1] - b_beats : -1;
      check("two_done_beat1", 32'(db0), 7);
      check("two_done_beat2", 32'(db1), 8);
      repeat (30) step_neg();
      check("two_drained_busy", 32'(bus.busy), 0);

      // unoccupied stage 3 reports done; wait continues until stage 0 does
      resp_on = 0; b_ack = n_ack; b_beats = n_beats;
      drive_edge(); man_done = 7'b0001000; bus.job_req = 1;
      wait_cnt(0, b_ack + 1, 20, "mask_ack");
      s = cyc;
      drive_edge(); bus.job_req = 0;
      repeat (7) drive_edge();
      man_done = 7'b0001001;
      drive_edge(); man_done = 7'b0001000;
      wait_cnt(2, b_beats + 2, 30, "mask_beat2");
      check("mask_gap", 32'(start_cyc - s), 10);
      check("mask_occ", 32'(bus.occupancy), 32'h02);

      // no done at all: watchdog fires after 20 wait cycles, then frozen
      s2 = start_cyc;
      drive_edge(); man_done = '0; bus.job_req = 1;
      while (cyc < s2 + 20) step_neg();
      check("timeout_before", 32'(bus.err), 0);
      step_neg();
      check("timeout_at", 32'(bus.err), 1);
      b_ack = n_ack; b_beats = n_beats;
      repeat (30) step_neg();
      check("halt_no_beats", 32'(n_beats - b_beats), 0);
      check("halt_no_acks",  32'(n_ack - b_ack),     0);
      check("halt_occ",      32'(bus.occupancy),     32'h02);
      check("halt_err",      32'(bus.err),           1);
      check("halt_busy",     32'(bus.busy),          1);
      drive_edge(); rst = 0; #1;
      check("halt_rst_err",  32'(bus.err),  0);
      check("halt_rst_busy", 32'(bus.busy), 0);
      drive_edge(); rst = 1; bus.job_req = 0;

      // reset in the middle of a wait with three jobs in flight
      resp_on = 1; fix_dly = 1; b_ack = n_ack;
      drive_edge(); bus.job_req = 1;
      wait_cnt(0, b_ack + 3, 40, "fill3_ack");
      check("fill3_occ", 32'(bus.occupancy), 32'h07);
      resp_on = 0; bus.job_req = 0;
      repeat (3) drive_edge();
      #2; rst = 0; #1;
      check("midrst_occ",   32'(bus.occupancy),   0);
      check("midrst_start", 32'(bus.stage_start), 0);
      check("midrst_ack",   32'(bus.job_ack),     0);
      check("midrst_jdone", 32'(bus.job_done),    0);
      check("midrst_busy",  32'(bus.busy),        0);
      check("midrst_err",   32'(bus.err),         0);
      drive_edge(); rst = 1;
      b_jd = n_jdone; b_beats = n_beats;
      repeat (30) step_neg();
      check("midrst_no_jdone", 32'(n_jdone - b_jd),   0);
      check("empty_no_beats",  32'(n_beats - b_beats), 0);
      check("empty_busy",      32'(bus.busy),          0);

      // random episodes; the long-delay episode can hit the watchdog
      for (int ep = 0; ep < 4; ep++) begin
         drive_edge(); rst = 0;
         drive_edge(); rst = 1;
         resp_on = 1; rand_dly = 1; noise_on = 1; man_done = '0;
         dly_max = (ep == 2) ? 30 : 12;
         for (int c = 0; c < 300; c++) begin
            drive_edge();
            bus.en      = ($urandom_range(0, 3) != 0);
            bus.job_req = ($urandom_range(0, 1) == 1);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pl_controller.md
PL_CONTROLLER -- requirements
Module: pl_controller

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 7, the number of pipeline stages sequenced.
REQ-002 SHALL have parameter TIMEOUT, default 65535, the maximum cycles allowed in WAIT per beat.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port en  input  1  permits a new beat to begin.
REQ-006 SHALL have port job_req  input  1  a new job is available at stage 0 input RAMs.
REQ-007 SHALL have port job_ack  output  1  one-cycle pulse: job_req accepted into stage 0.
REQ-008 SHALL have port stage_done  input  NUM_STAGES  per-stage done pulses or levels.
REQ-009 SHALL have port stage_start  output  NUM_STAGES  one-cycle start pulse per occupied stage; drives each stage's start_stage, which also flips its ping-pong RAMs.
REQ-010 SHALL have port occupancy  output  NUM_STAGES  valid bit per stage.
REQ-011 SHALL have port job_done  output  1  one-cycle pulse: the last stage finished a job.
REQ-012 SHALL have port busy  output  1  high when occupancy is nonzero or state is not IDLE.
REQ-013 SHALL have port err  output  1  sticky timeout flag.

Function
REQ-014 SHALL implement the states IDLE, START, WAIT and HALT.
REQ-015 IDLE: when en=1 and (job_req=1 or occupancy!=0), SHALL shift occupancy <= {occupancy[N-2:0], job_req}, pulse job_ack=job_req in the same cycle, and go to START.
REQ-016 IDLE with en=0, or with no job and empty occupancy, SHALL hold all state.
REQ-017 START SHALL last exactly one cycle, SHALL drive stage_start=occupancy, SHALL clear done_seen and the timeout counter, and SHALL go to WAIT.
REQ-018 stage_start SHALL be registered: it is high only during the START cycle, one cycle after the occupancy shift, which gives the RAMs a flip cycle.
REQ-019 WAIT SHALL update done_seen |= stage_done & occupancy each cycle; stage_done bits for unoccupied stages are ignored.
REQ-020 stage_done asserted during the START cycle SHALL be ignored.
REQ-021 WAIT SHALL go to IDLE in the cycle after done_seen equals occupancy; job_done SHALL pulse in that same transition cycle if occupancy[N-1]=1.
REQ-022 When the combined done arrives on the same cycle it is sampled, the WAIT-to-IDLE transition SHALL occur on the following edge, with no extra cycle.
REQ-023 en SHALL only gate new beats; WAIT SHALL complete regardless of en.
REQ-024 An empty pipeline with job_req=0 SHALL start no beat; a partially full pipeline SHALL keep beating with bubbles until it drains.
REQ-025 The minimum beat SHALL be IDLE->START->WAIT(≥1)->IDLE, i.e. 3 cycles.
REQ-026 The 16-bit timeout counter SHALL increment each WAIT cycle; reaching TIMEOUT SHALL set err=1 and go to HALT.
REQ-027 HALT SHALL be absorbing: no pulses, occupancy frozen, exit only by reset.

Reset
REQ-028 rst=0 SHALL asynchronously force state=IDLE and occupancy=0, done_seen=0, counter=0.
REQ-029 rst=0 SHALL asynchronously force job_ack=0, stage_start=0, job_done=0, err=0, busy=0.
REQ-030 A reset mid-WAIT SHALL discard all in-flight jobs; no job_done is issued for them.

Structure
REQ-031 The state encoding, NUM_STAGES default and TIMEOUT default SHALL reside in the shared NewHope pipeline package.
REQ-032 A single sub-module, done_collector (per-stage sticky done register with clear and mask), is natural; the FSM and counter SHALL remain in pl_controller.

Verification
REQ-033 Single job, N=7, each stage done 5 cycles after its start: 7 beats, a single job_ack, then job_done on the 7th beat exit; afterwards occupancy=0 and busy=0.
REQ-034 Two consecutive jobs with job_req held: occupancy goes 0000001 then 0000011; job_done pulses on beats 7 and 8.
REQ-035 Job in stage 0 only, with stage_done[3] asserted: WAIT does not exit until stage_done[0] arrives.
REQ-036 TIMEOUT=20 and stage_done never asserted: err=1 exactly 20 WAIT cycles after START; after that stage_start stays 0.
REQ-037 rst pulsed low mid-WAIT with occupancy=0000111: outputs are 0 immediately, and no job_done occurs afterwards.
REQ-038 en=0 in IDLE with job_req=1: no job_ack and no stage_start; after en=1, job_ack pulses on the next edge.
